// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational next-PC lookup for fetch; trained by branch resolve with a registered redirect.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_next_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = XLEN - INDEX_BITS - 2;

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [XLEN-1:0]   target_d [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [1:0]        ctr_d    [ENTRIES];

  logic              mispredict_q, mispredict_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [31:0]       branch_count_q, branch_count_d;
  logic [31:0]       mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0]      fetch_tag, upd_tag;
  logic                  fetch_hit, upd_hit;
  logic [ENTRIES-1:0]    upd_sel;

  assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag = fetch_pc[XLEN-1:INDEX_BITS+2];
  assign upd_idx   = upd_pc[INDEX_BITS+1:2];
  assign upd_tag   = upd_pc[XLEN-1:INDEX_BITS+2];

  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign pred_taken   = fetch_hit && ctr_q[fetch_idx][1];
  assign pred_next_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(4);

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
      assign upd_sel[gi] = upd_valid && (upd_idx == INDEX_BITS'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
      if (upd_sel[i]) begin
        if (upd_hit) begin
          if (upd_taken) begin
            ctr_d[i]    = (ctr_q[i] == 2'd3) ? 2'd3 : ctr_q[i] + 2'd1;
            target_d[i] = upd_target;
          end else begin
            ctr_d[i]    = (ctr_q[i] == 2'd0) ? 2'd0 : ctr_q[i] - 2'd1;
          end
        end else if (upd_taken) begin
          // Miss on a taken branch replaces whatever lived at this index.
          valid_d[i]  = 1'b1;
          tag_d[i]    = upd_tag;
          target_d[i] = upd_target;
          ctr_d[i]    = 2'b10;
        end
      end
    end
  end

  always_comb begin
    mispredict_d = upd_valid &&
                   ((upd_pred_taken != upd_taken) ||
                    (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc_d = redirect_pc_q;
    if (mispredict_d) begin
      redirect_pc_d = upd_taken ? upd_target : upd_pc + XLEN'(4);
    end
    branch_count_d     = branch_count_q + (upd_valid ? 32'd1 : 32'd0);
    mispredict_count_d = mispredict_count_q + (mispredict_d ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      mispredict_q       <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      mispredict_q       <= mispredict_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, hysteresis, aliasing,
// target change, back-to-back redirects and asynchronous reset mid-run.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.INDEX_BITS(4), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_next_pc    (pred_next_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .branch_count    (branch_count),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One update strobe; returns 1 ns after the capturing edge with upd_valid low.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    $display("upd pc=%h taken=%0d tgt=%h -> mispredict=%0d redirect=%h", pc, tk, tgt,
             mispredict, redirect_pc);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_pc);
    fetch_pc = pc;
    #1;
    $display("lookup pc=%h -> taken=%0d next=%h", pc, pred_taken, pred_next_pc);
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    check({tag, "_next"}, pred_next_pc, exp_pc);
  endtask

  initial begin
    rst = 1'b0;
    fetch_pc = 32'h0;
    upd_valid = 1'b0;
    upd_pc = 32'h0;
    upd_taken = 1'b0;
    upd_target = 32'h0;
    upd_pred_taken = 1'b0;
    upd_pred_target = 32'h0;
    #12 rst = 1'b1;
    @(negedge clk);

    // Reset state
    look("rst_look", 32'h40, 1'b0, 32'h44);
    check("rst_bcnt", branch_count, 32'd0);
    check("rst_mcnt", mispredict_count, 32'd0);
    check("rst_misp", {31'd0, mispredict}, 32'd0);
    check("rst_redir", redirect_pc, 32'd0);

    // Allocate 0x40 -> 0x100
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    check("alloc_misp", {31'd0, mispredict}, 32'd1);
    check("alloc_redir", redirect_pc, 32'h100);
    check("alloc_mcnt", mispredict_count, 32'd1);
    check("alloc_bcnt", branch_count, 32'd1);
    look("alloc_look", 32'h40, 1'b1, 32'h100);
    @(posedge clk);
    #1;
    check("pulse_end", {31'd0, mispredict}, 32'd0);

    // Hysteresis: 2 -> 1 -> 0 -> 1 -> 2
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    check("hy1_misp", {31'd0, mispredict}, 32'd1);
    check("hy1_redir", redirect_pc, 32'h44);
    look("hy1_look", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    check("hy2_misp", {31'd0, mispredict}, 32'd0);
    look("hy2_look", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    look("hy3_look", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    look("hy4_look", 32'h40, 1'b1, 32'h100);
    check("hy_bcnt", branch_count, 32'd5);
    check("hy_mcnt", mispredict_count, 32'd4);

    // Aliasing: 0x440 shares index 0 with 0x40
    upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h444);
    check("alias_redir", redirect_pc, 32'h200);
    look("alias_old", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'h440, 1'b1, 32'h200);

    // Re-allocate 0x40 then change its target; consecutive pulses with own redirects
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    check("b2b1_misp", {31'd0, mispredict}, 32'd1);
    check("b2b1_redir", redirect_pc, 32'h100);
    upd(32'h40, 1'b1, 32'h180, 1'b1, 32'h100);
    check("b2b2_misp", {31'd0, mispredict}, 32'd1);
    check("b2b2_redir", redirect_pc, 32'h180);
    look("tgt_look", 32'h40, 1'b1, 32'h180);
    look("lowbits_look", 32'h42, 1'b1, 32'h180);
    check("tgt_mcnt", mispredict_count, 32'd7);
    check("tgt_bcnt", branch_count, 32'd8);

    // Correct prediction: no pulse
    upd(32'h40, 1'b1, 32'h180, 1'b1, 32'h180);
    check("ok_misp", {31'd0, mispredict}, 32'd0);
    check("ok_mcnt", mispredict_count, 32'd7);

    // Same-cycle lookup/update of one index sees pre-update state
    @(negedge clk);
    fetch_pc = 32'h40;
    upd_valid = 1'b1;
    upd_pc = 32'h40;
    upd_taken = 1'b0;
    upd_target = 32'h0;
    upd_pred_taken = 1'b1;
    upd_pred_target = 32'h180;
    #1;
    check("same_next", pred_next_pc, 32'h180);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    check("same_redir", redirect_pc, 32'h44);
    look("same_after", 32'h40, 1'b1, 32'h180);

    // Not-taken miss leaves table alone but still mispredicts
    upd(32'h440, 1'b0, 32'h0, 1'b1, 32'h200);
    check("nt_misp", {31'd0, mispredict}, 32'd1);
    check("nt_redir", redirect_pc, 32'h444);
    check("nt_bcnt", branch_count, 32'd11);
    check("nt_mcnt", mispredict_count, 32'd9);
    look("nt_look", 32'h440, 1'b0, 32'h444);

    // Asynchronous reset while pulse is high
    #1 rst = 1'b0;
    #1;
    check("arst_misp", {31'd0, mispredict}, 32'd0);
    check("arst_redir", redirect_pc, 32'd0);
    check("arst_bcnt", branch_count, 32'd0);
    check("arst_mcnt", mispredict_count, 32'd0);
    look("arst_look", 32'h40, 1'b0, 32'h44);
    rst = 1'b1;
    @(negedge clk);
    look("post_look", 32'h40, 1'b0, 32'h44);
    look("post_look2", 32'h440, 1'b0, 32'h444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
